ctrl_banco_write: RTL and testbench

Write-back controller for the register bank's single write port in the multicycle processor. It arbitrates round-robin among the write-data sources: ALU result, load, shift register, Hi, Lo, PC link and set-less-than. It drives the `BancoWriteData` select, `WriteReg` address and `RegWrite` strobe. After every reset it also runs the stack-pointer initialisation write using source 5, the constant 227. It sits between the control unit/functional units and the `BancoWriteData` mux plus register bank.

---
 rtl/ctrl_banco_write.sv | 144 ++++++++++++++
 tb/tb_ctrl_banco_write.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_banco_write.sv
// ctrl_banco_write
// Write-back controller for the register bank's single write port in the
// multicycle processor. Write-data sources take turns round-robin: ALU result,
// load, shift register, Hi, Lo, PC link and set-less-than. Index 5 belongs to
// the controller itself, which drives the constant 227 into the stack pointer
// once after every reset.
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   WriteEn        control-unit enable; when low, pending requests wait
//   req[7:0]       level-held write request per source (bit 5 ignored)
//   dest[39:0]     5-bit destination register per source, dest[5*i+4:5*i]
//   BancoWriteData registered source select to the write-data mux
//   WriteReg       registered destination register
//   RegWrite       registered register-bank write strobe
//   grant[7:0]     registered one-hot grant pulse (bit 5 always 0)
//   init_done      high once the stack-pointer write has been issued
module ctrl_banco_write #(
   parameter logic [4:0] SP_REG = 5'd29
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        WriteEn,
   input  logic [7:0]  req,
   input  logic [39:0] dest,
   output logic [2:0]  BancoWriteData,
   output logic [4:0]  WriteReg,
   output logic        RegWrite,
   output logic [7:0]  grant,
   output logic        init_done
);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   // Index 5 is the controller's own constant source and never arbitrates.
   localparam logic [7:0] RESERVED_MASK = 8'b0010_0000;
   localparam logic [2:0] SP_SOURCE     = 3'd5;

   state_t      state;
   state_t      nextState;
   logic [2:0]  last;
   logic [2:0]  nextLast;
   logic [2:0]  nextSel;
   logic [4:0]  nextWriteReg;
   logic        nextRegWrite;
   logic [7:0]  nextGrant;
   logic        nextInitDone;

   logic [7:0]  eligible;
   logic        found;
   logic [2:0]  winner;
   logic [2:0]  cand;
   logic [4:0]  destArr [8];

   // Unpack the flat destination bus so the winner can index it directly.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         destArr[i] = dest[5*i +: 5];
      end
   end

   // Round-robin search. The bit granted last cycle is masked so a requester
   // that has not yet dropped its level-held request is not written twice in
   // a row. The search starts just after the previous winner and wraps; an
   // offset of 8 lands back on the previous winner itself, which lets a lone
   // requester be served again once the mask has expired.
   always_comb begin
      eligible = req & ~RESERVED_MASK & ~grant;
      found    = 1'b0;
      winner   = 3'd0;
      cand     = 3'd0;
      for (int off = 1; off <= 8; off++) begin
         cand = last + 3'(off);
         if (!found && eligible[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Next-state and next-output logic. Select and register address hold their
   // previous values when idle; grant and strobe default to a single-cycle
   // pulse. INIT always issues the stack-pointer write regardless of WriteEn.
   // A winner whose destination is $zero still gets its grant so it retires,
   // but the bank write is suppressed.
   always_comb begin
      nextState    = state;
      nextLast     = last;
      nextSel      = BancoWriteData;
      nextWriteReg = WriteReg;
      nextRegWrite = 1'b0;
      nextGrant    = 8'h00;
      nextInitDone = init_done;
      case (state)
         INIT: begin
            nextSel      = SP_SOURCE;
            nextWriteReg = SP_REG;
            nextRegWrite = 1'b1;
            nextState    = RUN;
         end
         RUN: begin
            nextInitDone = 1'b1;
            if (WriteEn && found) begin
               nextGrant    = 8'h01 << winner;
               nextSel      = winner;
               nextWriteReg = destArr[winner];
               nextRegWrite = (destArr[winner] != 5'd0);
               nextLast     = winner;
            end
         end
         default: begin
            nextState = INIT;
         end
      endcase
   end

   // State and registered outputs. Reset drops any in-flight grant and sends
   // the controller back to INIT so the stack-pointer write repeats; the
   // pointer returns to 7 so the first search after init starts at index 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= INIT;
         last           <= 3'd7;
         BancoWriteData <= 3'd0;
         WriteReg       <= 5'd0;
         RegWrite       <= 1'b0;
         grant          <= 8'h00;
         init_done      <= 1'b0;
      end else begin
         state          <= nextState;
         last           <= nextLast;
         BancoWriteData <= nextSel;
         WriteReg       <= nextWriteReg;
         RegWrite       <= nextRegWrite;
         grant          <= nextGrant;
         init_done      <= nextInitDone;
      end
   end

endmodule

// File: tb/tb_ctrl_banco_write.sv
// tb_ctrl_banco_write
// Self-checking bench for ctrl_banco_write. Each scenario task drives one
// row of stimulus per clock, pushes the hand-derived expected output word
// {grant, BancoWriteData, WriteReg, RegWrite, init_done} onto a scoreboard
// queue, and pops and compares it one clock later. Destination registers
// are dest_i = 7 + i unless a scenario overrides one.
module tb_ctrl_banco_write;

   logic        clk;
   logic        reset;
   logic        WriteEn;
   logic [7:0]  req;
   logic [39:0] dest;
   logic [2:0]  BancoWriteData;
   logic [4:0]  WriteReg;
   logic        RegWrite;
   logic [7:0]  grant;
   logic        init_done;

   logic [17:0] sb [$];
   int          compared;
   int          mismatched;

   ctrl_banco_write #(.SP_REG(5'd29)) dut (
      .clk            (clk),
      .reset          (reset),
      .WriteEn        (WriteEn),
      .req            (req),
      .dest           (dest),
      .BancoWriteData (BancoWriteData),
      .WriteReg       (WriteReg),
      .RegWrite       (RegWrite),
      .grant          (grant),
      .init_done      (init_done)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Applies one stimulus row {reset, WriteEn, req}, records what the DUT
   // must show after the coming edge, and waits until just after that edge.
   task automatic drive(input logic [9:0] stim, input logic [17:0] expv);
      {reset, WriteEn, req} = stim;
      sb.push_back(expv);
      @(posedge clk);
      #1;
   endtask

   // Held reset zeroes everything; the first released edge issues the SP
   // write even with WriteEn low; init_done rises only after that cycle.
   task automatic test_reset();
      logic [9:0]  stim [5] = '{{1'b1,1'b1,8'h00}, {1'b1,1'b1,8'h00},
                                {1'b0,1'b0,8'h00}, {1'b0,1'b1,8'h00},
                                {1'b0,1'b0,8'h00}};
      logic [17:0] expv [5] = '{{8'h00,3'd0,5'd0,1'b0,1'b0},
                                {8'h00,3'd0,5'd0,1'b0,1'b0},
                                {8'h00,3'd5,5'd29,1'b1,1'b0},
                                {8'h00,3'd5,5'd29,1'b0,1'b1},
                                {8'h00,3'd5,5'd29,1'b0,1'b1}};
      logic [17:0] got, want;
      for (int i = 0; i < 5; i++) begin
         drive(stim[i], expv[i]);
         got  = {grant, BancoWriteData, WriteReg, RegWrite, init_done};
         want = sb.pop_front();
         compared++;
         if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL reset[%0d]: got grant=%h sel=%0d wr=%0d rw=%b done=%b, expected grant=%h sel=%0d wr=%0d rw=%b done=%b",
                     i, got[17:10], got[9:7], got[6:2], got[1], got[0],
                     want[17:10], want[9:7], want[6:2], want[1], want[0]);
         end
      end
   endtask

   // A lone request from source 1 gets a one-cycle grant one edge later.
   task automatic test_single();
      logic [9:0]  stim [2] = '{{1'b0,1'b1,8'h02}, {1'b0,1'b1,8'h00}};
      logic [17:0] expv [2] = '{{8'h02,3'd1,5'd8,1'b1,1'b1},
                                {8'h00,3'd1,5'd8,1'b0,1'b1}};
      logic [17:0] got, want;
      for (int i = 0; i < 2; i++) begin
         drive(stim[i], expv[i]);
         got  = {grant, BancoWriteData, WriteReg, RegWrite, init_done};
         want = sb.pop_front();
         compared++;
         if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL single[%0d]: got grant=%h sel=%0d wr=%0d rw=%b done=%b, expected grant=%h sel=%0d wr=%0d rw=%b done=%b",
                     i, got[17:10], got[9:7], got[6:2], got[1], got[0],
                     want[17:10], want[9:7], want[6:2], want[1], want[0]);
         end
      end
   endtask

   // All seven sources requesting continuously: back-to-back grants rotate
   // from just after the previous winner (1), skipping index 5.
   task automatic test_back_to_back();
      logic [2:0]  order [9] = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
      logic [17:0] got, want;
      for (int i = 0; i < 9; i++) begin
         drive({1'b0, 1'b1, 8'hDF},
               {8'h01 << order[i], order[i], 5'd7 + 5'(order[i]), 1'b1, 1'b1});
         got  = {grant, BancoWriteData, WriteReg, RegWrite, init_done};
         want = sb.pop_front();
         compared++;
         if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL rr[%0d]: got grant=%h sel=%0d wr=%0d rw=%b done=%b, expected grant=%h sel=%0d wr=%0d rw=%b done=%b",
                     i, got[17:10], got[9:7], got[6:2], got[1], got[0],
                     want[17:10], want[9:7], want[6:2], want[1], want[0]);
         end
      end
      drive({1'b0, 1'b1, 8'h00}, {8'h00, 3'd3, 5'd10, 1'b0, 1'b1});
      got  = {grant, BancoWriteData, WriteReg, RegWrite, init_done};
      want = sb.pop_front();
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL rr_idle: got grant=%h sel=%0d wr=%0d rw=%b done=%b, expected grant=%h sel=%0d wr=%0d rw=%b done=%b",
                  got[17:10], got[9:7], got[6:2], got[1], got[0],
                  want[17:10], want[9:7], want[6:2], want[1], want[0]);
      end
   endtask

   // A single request held across its grant is masked for one edge, then
   // served again as new; a request on reserved bit 5 is never granted.
   task automatic test_hold_and_reserved();
      logic [9:0]  stim [6] = '{{1'b0,1'b1,8'h10}, {1'b0,1'b1,8'h10},
                                {1'b0,1'b1,8'h10}, {1'b0,1'b1,8'h20},
                                {1'b0,1'b1,8'h20}, {1'b0,1'b1,8'h00}};
      logic [17:0] expv [6] = '{{8'h10,3'd4,5'd11,1'b1,1'b1},
                                {8'h00,3'd4,5'd11,1'b0,1'b1},
                                {8'h10,3'd4,5'd11,1'b1,1'b1},
                                {8'h00,3'd4,5'd11,1'b0,1'b1},
                                {8'h00,3'd4,5'd11,1'b0,1'b1},
                                {8'h00,3'd4,5'd11,1'b0,1'b1}};
      logic [17:0] got, want;
      for (int i = 0; i < 6; i++) begin
         drive(stim[i], expv[i]);
         got  = {grant, BancoWriteData, WriteReg, RegWrite, init_done};
         want = sb.pop_front();
         compared++;
         if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL hold[%0d]: got grant=%h sel=%0d wr=%0d rw=%b done=%b, expected grant=%h sel=%0d wr=%0d rw=%b done=%b",
                     i, got[17:10], got[9:7], got[6:2], got[1], got[0],
                     want[17:10], want[9:7], want[6:2], want[1], want[0]);
         end
      end
   endtask

   // Destination $zero: the grant is issued but the bank write is suppressed.
   task automatic test_zero_dest();
      logic [9:0]  stim [2] = '{{1'b0,1'b1,8'h40}, {1'b0,1'b1,8'h00}};
      logic [17:0] expv [2] = '{{8'h40,3'd6,5'd0,1'b0,1'b1},
                                {8'h00,3'd6,5'd0,1'b0,1'b1}};
      logic [17:0] got, want;
      dest[34:30] = 5'd0;
      for (int i = 0; i < 2; i++) begin
         drive(stim[i], expv[i]);
         got  = {grant, BancoWriteData, WriteReg, RegWrite, init_done};
         want = sb.pop_front();
         compared++;
         if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL zero_dest[%0d]: got grant=%h sel=%0d wr=%0d rw=%b done=%b, expected grant=%h sel=%0d wr=%0d rw=%b done=%b",
                     i, got[17:10], got[9:7], got[6:2], got[1], got[0],
                     want[17:10], want[9:7], want[6:2], want[1], want[0]);
         end
      end
      dest[34:30] = 5'd13;
   endtask

   // Requests wait while WriteEn is low, then drain in round-robin order.
   task automatic test_write_enable();
      logic [9:0]  stim [6] = '{{1'b0,1'b0,8'h09}, {1'b0,1'b0,8'h09},
                                {1'b0,1'b0,8'h09}, {1'b0,1'b1,8'h09},
                                {1'b0,1'b1,8'h08}, {1'b0,1'b1,8'h00}};
      logic [17:0] expv [6] = '{{8'h00,3'd6,5'd0,1'b0,1'b1},
                                {8'h00,3'd6,5'd0,1'b0,1'b1},
                                {8'h00,3'd6,5'd0,1'b0,1'b1},
                                {8'h01,3'd0,5'd7,1'b1,1'b1},
                                {8'h08,3'd3,5'd10,1'b1,1'b1},
                                {8'h00,3'd3,5'd10,1'b0,1'b1}};
      logic [17:0] got, want;
      for (int i = 0; i < 6; i++) begin
         drive(stim[i], expv[i]);
         got  = {grant, BancoWriteData, WriteReg, RegWrite, init_done};
         want = sb.pop_front();
         compared++;
         if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL write_en[%0d]: got grant=%h sel=%0d wr=%0d rw=%b done=%b, expected grant=%h sel=%0d wr=%0d rw=%b done=%b",
                     i, got[17:10], got[9:7], got[6:2], got[1], got[0],
                     want[17:10], want[9:7], want[6:2], want[1], want[0]);
         end
      end
   endtask

   // Reset during a grant cycle drops it, repeats the SP write, and the
   // still-held request is served first since the pointer restarts at 7.
   task automatic test_reset_mid();
      logic [9:0]  stim [5] = '{{1'b0,1'b1,8'h80}, {1'b1,1'b1,8'h80},
                                {1'b0,1'b1,8'h80}, {1'b0,1'b1,8'h80},
                                {1'b0,1'b1,8'h00}};
      logic [17:0] expv [5] = '{{8'h80,3'd7,5'd14,1'b1,1'b1},
                                {8'h00,3'd0,5'd0,1'b0,1'b0},
                                {8'h00,3'd5,5'd29,1'b1,1'b0},
                                {8'h80,3'd7,5'd14,1'b1,1'b1},
                                {8'h00,3'd7,5'd14,1'b0,1'b1}};
      logic [17:0] got, want;
      for (int i = 0; i < 5; i++) begin
         drive(stim[i], expv[i]);
         got  = {grant, BancoWriteData, WriteReg, RegWrite, init_done};
         want = sb.pop_front();
         compared++;
         if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL reset_mid[%0d]: got grant=%h sel=%0d wr=%0d rw=%b done=%b, expected grant=%h sel=%0d wr=%0d rw=%b done=%b",
                     i, got[17:10], got[9:7], got[6:2], got[1], got[0],
                     want[17:10], want[9:7], want[6:2], want[1], want[0]);
         end
      end
   endtask

   // Scenario sequence; each scenario leaves the arbiter pointer where the
   // next one's expectations assume it.
   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      WriteEn    = 1'b1;
      req        = 8'h00;
      for (int i = 0; i < 8; i++) begin
         dest[5*i +: 5] = 5'(7 + i);
      end
      #2;
      test_reset();
      test_single();
      test_back_to_back();
      test_hold_and_reserved();
      test_zero_dest();
      test_write_enable();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
